// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants, RGB565 pixel type and sync bundle used by
// the timing generator and every pixel source hanging off it.
package vga_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   localparam int CNT_W   = 10;
   localparam int CNT_MAX = 1 << CNT_W;
   localparam int RGB_W   = 16;

   typedef logic [RGB_W-1:0] rgb565_t;

   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
   } sync_t;

   // Blanked with both syncs released: the state the connector sees out of reset.
   localparam sync_t SYNC_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1};

   function automatic logic in_range(input logic [CNT_W-1:0] cnt, input int lo, input int hi);
      return (int'(cnt) >= lo) && (int'(cnt) < hi);
   endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// DEPTH-stage shift register for {de, hs, vs}, matching the pixel source latency.
module vga_sync_delay
   import vga_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic  pclk,
   input  logic  rst_n,
   input  sync_t sync_i,
   output sync_t sync_o
);

   sync_t [DEPTH-1:0] pipe_q;

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= SYNC_IDLE;
      end else begin
         pipe_q[0] <= sync_i;
         for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign sync_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: counters, registered de/X/Y and start strobes for
// pixel sources, and a delayed sync/blanking path feeding the DAC.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter int PIPE_DLY = 2
) (
   input  logic             pclk,
   input  logic             rst_n,
   output logic             de,
   output logic [CNT_W-1:0] X,
   output logic [CNT_W-1:0] Y,
   output logic             frame_start,
   output logic             line_start,
   input  logic [RGB_W-1:0] pix_in,
   output logic             vga_hs,
   output logic             vga_vs,
   output logic [RGB_W-1:0] vga_rgb
);

   localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_SYNC_BEG = H_ACTIVE + H_FP;
   localparam int V_SYNC_BEG = V_ACTIVE + V_FP;

   if (PIPE_DLY < 1 || PIPE_DLY > 4 || H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_params
      $error("vga_timing_gen: PIPE_DLY must be 1..4 and raster totals must fit the counters");
   end

   logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
   logic             de_q, de_d, fs_q, fs_d, ls_q, ls_d, hs_q, hs_d, vs_q, vs_d;
   logic [RGB_W-1:0] rgb_q, rgb_d;
   logic             h_wrap, v_wrap;
   sync_t            sync_dly;

   always_comb begin
      h_wrap  = (int'(h_cnt_q) == H_TOTAL - 1);
      v_wrap  = (int'(v_cnt_q) == V_TOTAL - 1);
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;

      de_d = in_range(h_cnt_q, 0, H_ACTIVE) && in_range(v_cnt_q, 0, V_ACTIVE);
      x_d  = de_d ? h_cnt_q : '0;
      y_d  = de_d ? v_cnt_q : '0;
      fs_d = de_d && (h_cnt_q == '0) && (v_cnt_q == '0);
      ls_d = de_d && (h_cnt_q == '0);
      hs_d = !in_range(h_cnt_q, H_SYNC_BEG, H_SYNC_BEG + H_SYNC);
      vs_d = !in_range(v_cnt_q, V_SYNC_BEG, V_SYNC_BEG + V_SYNC);

      // Blank on the delayed de so a source's porch garbage never reaches the DAC.
      rgb_d = sync_dly.de ? pix_in : '0;
   end

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         de_q    <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         fs_q    <= 1'b0;
         ls_q    <= 1'b0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         rgb_q   <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         de_q    <= de_d;
         x_q     <= x_d;
         y_q     <= y_d;
         fs_q    <= fs_d;
         ls_q    <= ls_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         rgb_q   <= rgb_d;
      end
   end

   vga_sync_delay #(
      .DEPTH(PIPE_DLY)
   ) u_sync_delay (
      .pclk   (pclk),
      .rst_n  (rst_n),
      .sync_i ('{de: de_q, hs: hs_q, vs: vs_q}),
      .sync_o (sync_dly)
   );

   assign de          = de_q;
   assign X           = x_q;
   assign Y           = y_q;
   assign frame_start = fs_q;
   assign line_start  = ls_q;
   assign vga_hs      = sync_dly.hs;
   assign vga_vs      = sync_dly.vs;
   assign vga_rgb     = rgb_q;

endmodule
